// File: rtl/conn_probe_pkg.sv
// Shared types and constants for the tt_um_conn_probe connectivity probe.
// Optional embedded properties in the top are enabled with CONN_PROBE_FORMAL_EN.
package conn_probe_pkg;

  typedef enum logic [1:0] {
    MODE_LOOP   = 2'd0,
    MODE_WALK   = 2'd1,
    MODE_CHECK  = 2'd2,
    MODE_REPORT = 2'd3
  } mode_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOP   = 3'd1,
    S_WALK   = 3'd2,
    S_CHECK  = 3'd3,
    S_REPORT = 3'd4
  } state_t;

  localparam int W_MIN = 4;
  localparam int W_MAX = 8;

  // Status slice select: bit 2 picks err_cnt over cyc_cnt, bits 1:0 pick the W-bit lane.
  localparam int SLICE_ERR_BIT = 2;
  localparam int SLICE_LANE_W  = 2;

  localparam logic [W_MAX-1:0] LFSR_SEED_MAX = 8'hFF;

  // Maximal-length Fibonacci tap masks, bit i set means tap (i+1).
  function automatic logic [W_MAX-1:0] lfsr_taps(input int w);
    case (w)
      4:       return 8'h0C;
      5:       return 8'h14;
      6:       return 8'h30;
      7:       return 8'h60;
      default: return 8'hB8;
    endcase
  endfunction

  function automatic state_t mode_state(input mode_t m);
    case (m)
      MODE_LOOP:  return S_LOOP;
      MODE_WALK:  return S_WALK;
      MODE_CHECK: return S_CHECK;
      default:    return S_REPORT;
    endcase
  endfunction

endpackage

// File: rtl/conn_probe_lfsr.sv
// W-bit Fibonacci LFSR: shifts left, parity of the tapped bits enters bit 0.
// Reset and load both return it to the all-ones seed.
module conn_probe_lfsr
  import conn_probe_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         advance,
  output logic [W-1:0] value
);

  localparam logic [W_MAX-1:0] TAPS_FULL = lfsr_taps(W);
  localparam logic [W-1:0]     TAPS      = TAPS_FULL[W-1:0];
  localparam logic [W-1:0]     SEED      = LFSR_SEED_MAX[W-1:0];

  logic feedback;

  assign feedback = ^(value & TAPS);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value <= SEED;
    end else if (load) begin
      value <= SEED;
    end else if (advance) begin
      value <= {value[W-2:0], feedback};
    end
  end

endmodule

// File: rtl/tt_um_conn_probe.sv
// Tile connectivity probe: loopback, walking-one, LFSR checker and counter readout.
// Define CONN_PROBE_FORMAL_EN to compile in the embedded properties and covers.
module tt_um_conn_probe
  import conn_probe_pkg::*;
#(
  parameter int W     = 8,
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  input  logic [W-1:0] ui_in,
  output logic [W-1:0] uo_out,
  input  logic [W-1:0] uio_in,
  output logic [W-1:0] uio_out,
  output logic [W-1:0] uio_oe
);

  generate
    if (W < W_MIN || W > W_MAX) begin : g_bad_w
      $error("tt_um_conn_probe: W must be in 4..8");
    end
    if (CNT_W < W || CNT_W > 4 * W) begin : g_bad_cnt_w
      $error("tt_um_conn_probe: CNT_W must be in W..4*W");
    end
  endgenerate

  state_t state, state_next;
  mode_t  mode;

  logic [W-1:0]     pattern, lfsr_value;
  logic [W-1:0]     uo_reg, uio_out_reg, uio_oe_reg;
  logic [W-1:0]     uo_next, uio_out_next, uio_oe_next;
  logic [CNT_W-1:0] cyc_cnt, err_cnt;
  logic [4*W-1:0]   cyc_ext, err_ext;
  logic [SLICE_LANE_W-1:0] slice_lane;
  logic enter_walk, enter_check, check_active, mismatch, clear;

  assign mode         = mode_t'(ui_in[W-1:W-2]);
  assign cyc_ext      = (4*W)'(cyc_cnt);
  assign err_ext      = (4*W)'(err_cnt);
  assign slice_lane   = ui_in[SLICE_LANE_W-1:0];
  assign enter_walk   = (state_next == S_WALK)  && (state != S_WALK);
  assign enter_check  = (state_next == S_CHECK) && (state != S_CHECK);
  assign check_active = ena && (state == S_CHECK);
  assign mismatch     = (uio_in != lfsr_value);
  assign clear        = ena && (state == S_REPORT) && ui_in[3];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Output registers follow the state held this cycle, so a mode change never mixes lanes.
  always_comb begin
    state_next   = S_IDLE;
    uo_next      = '0;
    uio_out_next = '0;
    uio_oe_next  = '0;
    if (ena) begin
      state_next = mode_state(mode);
      case (state)
        S_LOOP:  uo_next = ui_in;
        S_WALK: begin
          uo_next      = pattern;
          uio_out_next = ~pattern;
          uio_oe_next  = '1;
        end
        S_CHECK: uo_next = err_cnt[W-1:0];
        S_REPORT: begin
          if (ui_in[SLICE_ERR_BIT]) begin
            uo_next = err_ext[slice_lane*W +: W];
          end else begin
            uo_next = cyc_ext[slice_lane*W +: W];
          end
        end
        default: uo_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pattern     <= '0;
      cyc_cnt     <= '0;
      err_cnt     <= '0;
      uo_reg      <= '0;
      uio_out_reg <= '0;
      uio_oe_reg  <= '0;
    end else begin
      uo_reg      <= uo_next;
      uio_out_reg <= uio_out_next;
      uio_oe_reg  <= uio_oe_next;
      if (enter_walk) begin
        pattern <= W'(1);
      end else if (ena && state == S_WALK) begin
        pattern <= {pattern[W-2:0], pattern[W-1]};
      end
      // Clear wins over both the cycle increment and any error increment.
      if (clear) begin
        cyc_cnt <= '0;
        err_cnt <= '0;
      end else begin
        if (ena && cyc_cnt != '1) cyc_cnt <= cyc_cnt + CNT_W'(1);
        if (check_active && mismatch && err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
      end
    end
  end

  conn_probe_lfsr #(.W(W)) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (enter_check),
    .advance (check_active),
    .value   (lfsr_value)
  );

  assign uo_out  = ena ? uo_reg      : '0;
  assign uio_out = ena ? uio_out_reg : '0;
  assign uio_oe  = ena ? uio_oe_reg  : '0;

`ifdef CONN_PROBE_FORMAL_EN
  logic past_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) past_valid <= 1'b1;
  end

  a_ena_gate: assert property (@(posedge clk)
    !ena |-> (uo_out == '0 && uio_out == '0 && uio_oe == '0));

  a_loop_echo: assert property (@(posedge clk)
    past_valid && ena && $past(ena) && $past(rst_n) && $past(state) == S_LOOP
    |-> uo_out == $past(ui_in));

  a_walk_onehot: assert property (@(posedge clk)
    past_valid && ena && $past(ena) && $past(rst_n) && $past(state) == S_WALK
    |-> $onehot(uo_out));

  a_cnt_mono: assert property (@(posedge clk)
    past_valid && $past(rst_n) && !$past(clear)
    |-> (cyc_cnt >= $past(cyc_cnt) && err_cnt >= $past(err_cnt)));

  c_idle:   cover property (@(posedge clk) state == S_IDLE);
  c_loop:   cover property (@(posedge clk) state == S_LOOP);
  c_walk:   cover property (@(posedge clk) state == S_WALK);
  c_check:  cover property (@(posedge clk) state == S_CHECK);
  c_report: cover property (@(posedge clk) state == S_REPORT);
`else
  // Default build carries no embedded properties; the datapath above is unchanged.
`endif

endmodule
